// File: rtl/fp_cmp_acc_ci_if.sv
// Issue/complete bus of the fp_cmp_acc_ci custom instruction.
// The CPU side drives operands and strobes; the unit returns result and done.
interface fp_cmp_acc_ci_if #(
   parameter int W = 32
);
   logic         clk_en;
   logic         start;
   logic [2:0]   n;
   logic [W-1:0] dataa;
   logic [W-1:0] datab;
   logic [W-1:0] result;
   logic         done;

   modport master (
      output clk_en, start, n, dataa, datab,
      input  result, done
   );

   modport slave (
      input  clk_en, start, n, dataa, datab,
      output result, done
   );
endinterface

// File: rtl/fp_cmp_acc_ci.sv
// Fixed-latency floating-point compare / MIN custom instruction with a
// running-minimum accumulator (value + node index) for frontier scans.
module fp_cmp_acc_ci #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int STAGES = 2,
   parameter int IDX_W  = 16
) (
   input logic         clk,
   input logic         reset,
   fp_cmp_acc_ci_if.slave bus
);
   localparam int W = 1 + EXP_W + MANT_W;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef logic [W-1:0] word_t;

   localparam word_t      POS_INF  = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
   localparam word_t      QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
   localparam logic [1:0] CNT_LOAD = 2'(STAGES - 1);

   function automatic logic is_nan(input word_t x);
      return (&x[W-2:MANT_W]) && (|x[MANT_W-1:0]);
   endfunction

   function automatic logic is_zero(input word_t x);
      return ~|x[W-2:0];
   endfunction

   // Sign-magnitude ordering for non-NaN operands; +0 and -0 are equal.
   function automatic logic lt_ord(input word_t a, input word_t b);
      if (is_zero(a) && is_zero(b)) return 1'b0;
      if (a[W-1] != b[W-1])          return a[W-1];
      if (a[W-1])                    return a[W-2:0] > b[W-2:0];
      return a[W-2:0] < b[W-2:0];
   endfunction

   function automatic logic eq_ord(input word_t a, input word_t b);
      return (is_zero(a) && is_zero(b)) || (a == b);
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   word_t            a_q, a_d, b_q, b_d;
   word_t            result_q, result_d;
   logic             done_q, done_d;
   word_t            best_val_q, best_val_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             acc_valid_q, acc_valid_d;

   logic  a_nan, b_nan, lt_ab, lt_ba, eq_ab, push_ok;
   word_t op_res;

   assign a_nan   = is_nan(a_q);
   assign b_nan   = is_nan(b_q);
   assign lt_ab   = lt_ord(a_q, b_q);
   assign lt_ba   = lt_ord(b_q, a_q);
   assign eq_ab   = eq_ord(a_q, b_q);
   assign push_ok = !a_nan && (!acc_valid_q || lt_ord(a_q, best_val_q));

   always_comb begin
      op_res = '0;
      case (op_q)
         3'd0: op_res = W'(!a_nan && !b_nan && (lt_ab || eq_ab));
         3'd1: op_res = W'(!a_nan && !b_nan && lt_ab);
         3'd2: op_res = W'(!a_nan && !b_nan && eq_ab);
         3'd3: begin
            if (a_nan && b_nan) op_res = QNAN;
            else if (a_nan)     op_res = b_q;
            else if (b_nan)     op_res = a_q;
            else if (lt_ba)     op_res = b_q;
            else                op_res = a_q;
         end
         3'd4: op_res = '0;
         3'd5: op_res = W'(push_ok);
         3'd6: op_res = best_val_q;
         3'd7: op_res = acc_valid_q ? W'(best_idx_q) : '1;
         default: op_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      done_d      = done_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      acc_valid_d = acc_valid_q;
      // clk_en low leaves every register, including a pending done, untouched.
      if (bus.clk_en) begin
         done_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  op_d    = bus.n;
                  a_d     = bus.dataa;
                  b_d     = bus.datab;
                  cnt_d   = CNT_LOAD;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != 2'd0) begin
                  cnt_d = cnt_q - 2'd1;
               end else begin
                  state_d  = IDLE;
                  done_d   = 1'b1;
                  result_d = op_res;
                  if (op_q == 3'd4) begin
                     best_val_d  = POS_INF;
                     best_idx_d  = '1;
                     acc_valid_d = 1'b0;
                  end else if (op_q == 3'd5 && push_ok) begin
                     best_val_d  = a_q;
                     best_idx_d  = b_q[IDX_W-1:0];
                     acc_valid_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         best_val_q  <= POS_INF;
         best_idx_q  <= '1;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         done_q      <= done_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         acc_valid_q <= acc_valid_d;
      end
   end

   assign bus.result = result_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_fp_cmp_acc_ci.sv
// Scoreboard bench for fp_cmp_acc_ci: one vector table plus stall, busy-start
// and mid-op reset sequences, replayed against STAGES = 1, 2 and 4 instances.
module tb_fp_cmp_acc_ci;
   localparam int W = 32;

   localparam logic [W-1:0] ONE   = 32'h3F80_0000;
   localparam logic [W-1:0] TWO   = 32'h4000_0000;
   localparam logic [W-1:0] THREE = 32'h4040_0000;
   localparam logic [W-1:0] FIVE  = 32'h40A0_0000;
   localparam logic [W-1:0] QNAN  = 32'h7FC0_0000;
   localparam logic [W-1:0] PINF  = 32'h7F80_0000;
   localparam logic [W-1:0] ALL1  = 32'hFFFF_FFFF;

   typedef struct {
      logic [2:0]   n;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      string        name;
   } vec_t;

   typedef struct {
      logic [W-1:0] exp;
      string        name;
   } sb_t;

   logic         clk = 1'b0;
   logic         reset, clk_en, start;
   logic [2:0]   n;
   logic [W-1:0] dataa, datab;

   int           sel, stages;
   logic         cur_done;
   logic [W-1:0] cur_result;
   int           n_cmp = 0;
   int           n_fail = 0;
   vec_t         vecs[$];
   sb_t          sb[$];

   always #5 clk = ~clk;

   fp_cmp_acc_ci_if #(.W(W)) bus1 ();
   fp_cmp_acc_ci_if #(.W(W)) bus2 ();
   fp_cmp_acc_ci_if #(.W(W)) bus4 ();

   assign bus1.clk_en = clk_en; assign bus1.start = start; assign bus1.n = n;
   assign bus1.dataa  = dataa;  assign bus1.datab = datab;
   assign bus2.clk_en = clk_en; assign bus2.start = start; assign bus2.n = n;
   assign bus2.dataa  = dataa;  assign bus2.datab = datab;
   assign bus4.clk_en = clk_en; assign bus4.start = start; assign bus4.n = n;
   assign bus4.dataa  = dataa;  assign bus4.datab = datab;

   fp_cmp_acc_ci #(.EXP_W(8), .MANT_W(23), .STAGES(1), .IDX_W(16))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));
   fp_cmp_acc_ci #(.EXP_W(8), .MANT_W(23), .STAGES(2), .IDX_W(16))
      dut2 (.clk(clk), .reset(reset), .bus(bus2));
   fp_cmp_acc_ci #(.EXP_W(8), .MANT_W(23), .STAGES(4), .IDX_W(16))
      dut4 (.clk(clk), .reset(reset), .bus(bus4));

   always_comb begin
      case (sel)
         0:       begin cur_done = bus1.done; cur_result = bus1.result; end
         1:       begin cur_done = bus2.done; cur_result = bus2.result; end
         default: begin cur_done = bus4.done; cur_result = bus4.result; end
      endcase
   end

   task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s (STAGES=%0d): got %h, expected %h", name, stages, act, exp);
      end
   endtask

   task automatic addVec(input logic [2:0] vn, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vexp, input string vname);
      vec_t v;
      v.n = vn; v.a = va; v.b = vb; v.exp = vexp; v.name = vname;
      vecs.push_back(v);
   endtask

   // Issue one instruction; returns at #1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] vn, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [W-1:0] vexp, input string vname);
      sb_t e;
      @(negedge clk);
      start = 1'b1; n = vn; dataa = va; datab = vb;
      e.exp = vexp; e.name = vname;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait a bounded number of edges for done, check latency, pop and compare.
   task automatic checkOutput(input int exp_lat);
      int  lat;
      sb_t e;
      lat = 0;
      for (int j = 1; j <= stages + 8; j++) begin
         @(posedge clk);
         #1;
         if (cur_done) begin
            lat = j;
            break;
         end
      end
      if (lat == 0) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL done_timeout (STAGES=%0d): got no done, expected done after %0d edges", stages, exp_lat);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      checkVal("latency", W'(lat), W'(exp_lat));
      if (sb.size() == 0) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL unexpected_done (STAGES=%0d): got done, expected none pending", stages);
      end else begin
         e = sb.pop_front();
         checkVal(e.name, cur_result, e.exp);
      end
   endtask

   task automatic countDones(input int cycles, output int cnt);
      cnt = 0;
      for (int j = 0; j < cycles; j++) begin
         @(posedge clk);
         #1;
         if (cur_done) cnt++;
      end
   endtask

   initial begin
      int extra;
      reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
      sel = 0; stages = 1;

      addVec(3'd7, '0, '0, ALL1, "empty_idx");
      addVec(3'd6, '0, '0, PINF, "empty_val");
      addVec(3'd0, ONE, TWO, 32'd1, "le_1_2");
      addVec(3'd1, TWO, ONE, 32'd0, "lt_2_1");
      addVec(3'd2, 32'h0, 32'h8000_0000, 32'd1, "eq_pz_nz");
      addVec(3'd0, 32'hC000_0000, 32'hBF80_0000, 32'd1, "le_n2_n1");
      addVec(3'd1, 32'hBF80_0000, 32'hC000_0000, 32'd0, "lt_n1_n2");
      addVec(3'd0, TWO, ONE, 32'd0, "le_2_1");
      addVec(3'd1, 32'h1, 32'h2, 32'd1, "lt_denorm");
      addVec(3'd1, 32'h8000_0001, 32'h0, 32'd1, "lt_negdenorm_zero");
      addVec(3'd1, ONE, 32'hBF80_0000, 32'd0, "lt_pos_neg");
      addVec(3'd2, ONE, ONE, 32'd1, "eq_1_1");
      addVec(3'd0, ONE, ONE, 32'd1, "le_equal");
      addVec(3'd1, ONE, ONE, 32'd0, "lt_equal");
      addVec(3'd0, QNAN, ONE, 32'd0, "le_nan_1");
      addVec(3'd2, QNAN, QNAN, 32'd0, "eq_nan_nan");
      addVec(3'd1, PINF, 32'h7F80_0001, 32'd0, "lt_inf_snan");
      addVec(3'd3, QNAN, THREE, THREE, "min_nan_3");
      addVec(3'd3, THREE, 32'hFFC0_0001, THREE, "min_3_nan");
      addVec(3'd3, 32'h7F80_0001, 32'hFFC0_0000, QNAN, "min_nan_nan");
      addVec(3'd3, TWO, ONE, ONE, "min_2_1");
      addVec(3'd3, 32'h8000_0000, 32'h0, 32'h8000_0000, "min_nz_pz");
      addVec(3'd3, ONE, 32'hC000_0000, 32'hC000_0000, "min_1_n2");
      addVec(3'd4, '0, '0, 32'd0, "acc_clr");
      addVec(3'd5, FIVE, 32'd3, 32'd1, "push_5_i3");
      addVec(3'd5, TWO, 32'd7, 32'd1, "push_2_i7");
      addVec(3'd5, TWO, 32'd9, 32'd0, "push_2_i9_tie");
      addVec(3'd5, QNAN, 32'd1, 32'd0, "push_nan_i1");
      addVec(3'd6, '0, '0, TWO, "acc_val_2");
      addVec(3'd7, '0, '0, 32'd7, "acc_idx_7");
      addVec(3'd5, 32'hBF80_0000, 32'h0001_2345, 32'd1, "push_n1_wide_idx");
      addVec(3'd7, '0, '0, 32'h0000_2345, "acc_idx_trunc");
      addVec(3'd6, '0, '0, 32'hBF80_0000, "acc_val_n1");
      addVec(3'd4, '0, '0, 32'd0, "acc_clr2");
      addVec(3'd7, '0, '0, ALL1, "clr_idx");
      addVec(3'd6, '0, '0, PINF, "clr_val");

      for (int s = 0; s < 3; s++) begin
         sel    = s;
         stages = (s == 0) ? 1 : (s == 1) ? 2 : 4;
         $display("[TB] pass with STAGES=%0d", stages);
         reset = 1'b1;
         repeat (2) @(posedge clk);
         #1 reset = 1'b0;
         checkVal("reset_done", W'(cur_done), '0);
         checkVal("reset_result", cur_result, '0);

         foreach (vecs[i]) begin
            applyStimulus(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
            checkOutput(stages);
         end

         // Three stalled edges right after acceptance push done out by three.
         applyStimulus(3'd0, ONE, TWO, 32'd1, "stall_le");
         clk_en = 1'b0;
         repeat (3) @(posedge clk);
         #1 clk_en = 1'b1;
         checkOutput(stages);
         clk_en = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         checkVal("stall_hold_done", W'(cur_done), W'(1));
         checkVal("stall_hold_result", cur_result, 32'd1);
         clk_en = 1'b1;
         @(posedge clk);
         #1;
         checkVal("done_falls", W'(cur_done), '0);
         checkVal("result_holds", cur_result, 32'd1);

         // start held high throughout BUSY with different operands.
         applyStimulus(3'd1, ONE, TWO, 32'd1, "busy_start_lt");
         start = 1'b1; n = 3'd2; dataa = TWO; datab = THREE;
         checkOutput(stages);
         start = 1'b0;
         countDones(stages + 3, extra);
         checkVal("busy_no_extra_done", W'(extra), '0);

         // Reset one cycle into an ACC_PUSH aborts it and empties the accumulator.
         applyStimulus(3'd5, FIVE, 32'd3, 32'd1, "rst_push_pre");
         checkOutput(stages);
         applyStimulus(3'd5, ONE, 32'd4, 32'd1, "rst_push_abort");
         reset = 1'b1;
         @(posedge clk);
         #1 reset = 1'b0;
         void'(sb.pop_back());
         checkVal("rst_mid_result", cur_result, '0);
         countDones(stages + 3, extra);
         checkVal("rst_no_done", W'(extra), '0);
         applyStimulus(3'd7, '0, '0, ALL1, "rst_idx");
         checkOutput(stages);
         applyStimulus(3'd6, '0, '0, PINF, "rst_val");
         checkOutput(stages);
      end

      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_cmp_acc_ci.md
# fp_cmp_acc_ci

Parametrised multi-cycle floating-point compare custom instruction for the Nios II datapath of the Dijkstra check-step IP. It performs IEEE-style ordered compares (LE, LT, EQ) and MIN on two operands. It also keeps an internal running-minimum accumulator with node index, so a frontier scan can locate the next closest node without software compare loops. Operations are selected per instruction by `n`, with a fixed-latency start/done handshake.

## Interface
- `EXP_W`, 8, exponent width.
- `MANT_W`, 23, mantissa width; operand width W = 1+EXP_W+MANT_W (32 by default).
- `STAGES`, 2, fixed latency in cycles from accepted start to done; legal 1..4.
- `IDX_W`, 16, accumulator node-index width; must be <= W.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `clk_en`  in  1  global stall; low freezes every register, including done and result.
- `start`  in  1  instruction issue strobe.
- `n`  in  3  operation select.
- `dataa`  in  W  operand A / push value.
- `datab`  in  W  operand B / push index (low IDX_W bits).
- `result`  out  W  registered result.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **Decode:** sign s, exponent e, mantissa m.
  - NaN: e all ones, m != 0.
  - +0 and -0 are equal.
  - Denormals compare exactly; no flush.
- **Ordering:** sign-magnitude ordering. Both negative reverses the magnitude comparison.
- **Ops by `n`:**
  - 0 LE: result = 1 if A <= B, else 0.
  - 1 LT: result = 1 if A < B.
  - 2 EQ: result = 1 if A == B.
  - 3 MIN: result = smaller operand.
    - A == B returns A.
    - One NaN returns the other operand.
    - Both NaN returns canonical qNaN: sign 0, e all ones, m MSB 1, rest 0.
  - 4 ACC_CLR: best_val = +inf, best_idx = all ones, acc_valid = 0; result = 0.
  - 5 ACC_PUSH: if A is not NaN and (acc_valid == 0 or A < best_val), then best_val = A, best_idx = B[IDX_W-1:0], acc_valid = 1, result = 1; otherwise no change, result = 0.
    - Ties keep the earlier entry.
  - 6 ACC_VAL: result = best_val.
  - 7 ACC_IDX: result = zero-extended best_idx when acc_valid; otherwise all ones.
- **NaN in compares:** any NaN operand makes LE, LT and EQ return 0.
- **Result width:** compare results are zero-extended to W.
- **FSM:**
  - IDLE: `start` & `clk_en` latches n, dataa and datab, loads cnt = STAGES-1, and enters BUSY.
  - BUSY: cnt decrements each enabled cycle. At cnt == 0 it writes result and updates the accumulator in the same edge, pulses done, and returns to IDLE.
  - With STAGES == 1, BUSY lasts one cycle.
- **start while BUSY:** ignored. No re-latch, no second done.
- **Reset state:**
  - result = 0, done = 0, FSM IDLE.
  - best_val = +inf (0x7F800000 at default widths), best_idx = all ones, acc_valid = 0.
- **Reset mid-operation:** aborts the instruction. No done is produced, and the accumulator takes its reset value.

## Timing
- Start accepted at edge k gives done = 1 for exactly one enabled cycle after edge k+STAGES; result is valid in that same cycle.
- result holds its value until the next completion; it is not cleared when done falls.
- Back-to-back issue: start may be asserted in the done cycle, giving a throughput of one op per STAGES+1 cycles.
- `clk_en` low:
  - Freezes cnt, FSM, result and done; a pending done stays high until clk_en returns.
  - start is not sampled.
- Accumulator state is visible to the next instruction: ACC_VAL issued right after an ACC_PUSH completes returns the updated value.

## Test plan
- **Ordered compares:** LE(1.0 = 0x3F800000, 2.0 = 0x40000000) = 1 and LT(2.0, 1.0) = 0. EQ(0x00000000, 0x80000000) = 1. LE(-2.0 = 0xC0000000, -1.0 = 0xBF800000) = 1. done appears exactly STAGES cycles after start.
- **NaN:** LE(0x7FC00000, 1.0) = 0 and EQ(NaN, NaN) = 0. MIN(NaN, 3.0) = 0x40400000. MIN(NaN, NaN) = 0x7FC00000.
- **Accumulator scan:**
  - ACC_CLR, then push (5.0, idx 3), (2.0, idx 7), (2.0, idx 9), (NaN, idx 1).
  - Push results are 1, 1, 0, 0.
  - ACC_VAL = 0x40000000, ACC_IDX = 7.
- **Empty accumulator:** after reset or ACC_CLR, ACC_IDX = all ones and ACC_VAL = 0x7F800000.
- **Stall and ignored start:**
  - Hold clk_en low for 3 cycles mid-BUSY; done is delayed by exactly 3 cycles.
  - A start pulse during BUSY produces no extra done, and the operands are not overwritten.
- **Reset mid-op:** assert reset one cycle after an ACC_PUSH start. No done follows, and ACC_IDX then reads all ones. Repeat the tests at STAGES = 1 and 4.
